// File: rtl/vrf_banked_mp_if.sv
// vrf_banked_mp_if: read-group, read-response and write-port bundle for the banked VRF.
// master = dispatch/writeback side, slave = register file.
interface vrf_banked_mp_if #(
    parameter int unsigned RPORT_NUM = 3,
    parameter int unsigned WPORT_NUM = 2,
    parameter int unsigned NUM_VREGS = 32,
    parameter int unsigned VLEN      = 128
);
    localparam int unsigned AW = $clog2(NUM_VREGS);

    logic                        rd_req_vld;
    logic                        rd_req_rdy;
    logic [RPORT_NUM-1:0]        rd_req_en;
    logic [RPORT_NUM*AW-1:0]     rd_req_addr;
    logic [RPORT_NUM-1:0]        rd_rsp_vld;
    logic [RPORT_NUM*VLEN-1:0]   rd_rsp_data;
    logic [WPORT_NUM-1:0]        wr_vld;
    logic [WPORT_NUM-1:0]        wr_rdy;
    logic [WPORT_NUM*AW-1:0]     wr_addr;
    logic [WPORT_NUM*VLEN-1:0]   wr_mask;
    logic [WPORT_NUM*VLEN-1:0]   wr_data;

    modport master (
        output rd_req_vld, rd_req_en, rd_req_addr,
        output wr_vld, wr_addr, wr_mask, wr_data,
        input  rd_req_rdy, rd_rsp_vld, rd_rsp_data, wr_rdy
    );

    modport slave (
        input  rd_req_vld, rd_req_en, rd_req_addr,
        input  wr_vld, wr_addr, wr_mask, wr_data,
        output rd_req_rdy, rd_rsp_vld, rd_rsp_data, wr_rdy
    );
endinterface

// File: rtl/vrf_banked_mp.sv
// vrf_banked_mp: banked vector register file; grouped multi-cycle reads, per-port write skids.
// Define VRF_WR_BYPASS_EN to forward a same-cycle winning write into a read of the same register.
module vrf_banked_mp #(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned BANK_RPORTS = 2,
    parameter int unsigned RPORT_NUM   = 3,
    parameter int unsigned WPORT_NUM   = 2,
    parameter int unsigned NUM_VREGS   = 32,
    parameter int unsigned VLEN        = 128
) (
    input  logic           clk,
    input  logic           rst,
    vrf_banked_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_VREGS);
    localparam int unsigned BW = $clog2(NUM_BANKS);
    localparam int unsigned CW = $clog2(RPORT_NUM + BANK_RPORTS + 1);

    typedef enum logic [0:0] {S_IDLE, S_SERVE} state_e;

    // Storage index equals the vreg address: low bits pick the bank, high bits the row.
    logic [VLEN-1:0] mem_q [NUM_VREGS];

    state_e               state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic [RPORT_NUM-1:0] pend_q, pend_d, rgnt;
    logic [AW-1:0]        raddr_q [RPORT_NUM];
    logic [AW-1:0]        raddr_d [RPORT_NUM];
    logic [RPORT_NUM-1:0] rsp_vld_q, rsp_vld_d;
    logic [VLEN-1:0]      rsp_data_q [RPORT_NUM];
    logic [VLEN-1:0]      rsp_data_d [RPORT_NUM];
    logic [VLEN-1:0]      rd_val [RPORT_NUM];

    logic [WPORT_NUM-1:0] skid_vld_q, skid_vld_d;
    logic [WPORT_NUM-1:0] wr_rdy_q, wr_rdy_d;
    logic [AW-1:0]        skid_addr_q [WPORT_NUM];
    logic [AW-1:0]        skid_addr_d [WPORT_NUM];
    logic [VLEN-1:0]      skid_mask_q [WPORT_NUM];
    logic [VLEN-1:0]      skid_mask_d [WPORT_NUM];
    logic [VLEN-1:0]      skid_data_q [WPORT_NUM];
    logic [VLEN-1:0]      skid_data_d [WPORT_NUM];

    logic [WPORT_NUM-1:0] cand_skid, cand_new, wgnt;
    logic [AW-1:0]        c_addr [WPORT_NUM];
    logic [VLEN-1:0]      c_mask [WPORT_NUM];
    logic [VLEN-1:0]      c_data [WPORT_NUM];

    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
        return a[BW-1:0];
    endfunction

    // Each write port offers at most one candidate: its held skid, else a newly accepted write.
    always_comb begin
        for (int p = 0; p < WPORT_NUM; p++) begin
            cand_skid[p] = skid_vld_q[p];
            cand_new[p]  = bus.wr_vld[p] & wr_rdy_q[p];
            c_addr[p]    = skid_vld_q[p] ? skid_addr_q[p] : bus.wr_addr[p*AW +: AW];
            c_mask[p]    = skid_vld_q[p] ? skid_mask_q[p] : bus.wr_mask[p*VLEN +: VLEN];
            c_data[p]    = skid_vld_q[p] ? skid_data_q[p] : bus.wr_data[p*VLEN +: VLEN];
        end
    end

    // One write per bank: all skid retries outrank new writes, lower port breaks ties.
    always_comb begin
        logic [NUM_BANKS-1:0] busy;
        busy = '0;
        wgnt = '0;
        for (int p = 0; p < WPORT_NUM; p++) begin
            if (cand_skid[p] && !busy[bank_of(c_addr[p])]) begin
                wgnt[p]                  = 1'b1;
                busy[bank_of(c_addr[p])] = 1'b1;
            end
        end
        for (int p = 0; p < WPORT_NUM; p++) begin
            if (cand_new[p] && !busy[bank_of(c_addr[p])]) begin
                wgnt[p]                  = 1'b1;
                busy[bank_of(c_addr[p])] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < WPORT_NUM; p++) begin
            skid_vld_d[p]  = skid_vld_q[p];
            skid_addr_d[p] = skid_addr_q[p];
            skid_mask_d[p] = skid_mask_q[p];
            skid_data_d[p] = skid_data_q[p];
            if (cand_skid[p] && wgnt[p]) begin
                skid_vld_d[p] = 1'b0;
            end else if (cand_new[p] && !wgnt[p]) begin
                skid_vld_d[p]  = 1'b1;
                skid_addr_d[p] = c_addr[p];
                skid_mask_d[p] = c_mask[p];
                skid_data_d[p] = c_data[p];
            end
        end
        wr_rdy_d = ~skid_vld_d;
    end

    // Read-port grant: up to BANK_RPORTS pending ports per bank, lowest index first.
    always_comb begin
        logic [CW-1:0] cnt [NUM_BANKS];
        for (int b = 0; b < NUM_BANKS; b++) cnt[b] = '0;
        rgnt = '0;
        if (state_q == S_SERVE) begin
            for (int p = 0; p < RPORT_NUM; p++) begin
                if (pend_q[p] && (cnt[bank_of(raddr_q[p])] < CW'(BANK_RPORTS))) begin
                    rgnt[p]                     = 1'b1;
                    cnt[bank_of(raddr_q[p])]    = cnt[bank_of(raddr_q[p])] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RPORT_NUM; r++) begin
            rd_val[r] = mem_q[raddr_q[r]];
`ifdef VRF_WR_BYPASS_EN
            for (int w = 0; w < WPORT_NUM; w++) begin
                if (wgnt[w] && (c_addr[w] == raddr_q[r])) begin
                    rd_val[r] = (rd_val[r] & ~c_mask[w]) | (c_data[w] & c_mask[w]);
                end
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        raddr_d    = raddr_q;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rd_req_vld && rdy_q) begin
                    for (int r = 0; r < RPORT_NUM; r++) raddr_d[r] = bus.rd_req_addr[r*AW +: AW];
                    pend_d = bus.rd_req_en;
                    if (|bus.rd_req_en) state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                pend_d = pend_q & ~rgnt;
                for (int r = 0; r < RPORT_NUM; r++) begin
                    if (rgnt[r]) begin
                        rsp_vld_d[r]  = 1'b1;
                        rsp_data_d[r] = rd_val[r];
                    end
                end
                if (pend_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b1;
            pend_q     <= '0;
            rsp_vld_q  <= '0;
            skid_vld_q <= '0;
            wr_rdy_q   <= '1;
            for (int r = 0; r < RPORT_NUM; r++) begin
                raddr_q[r]    <= '0;
                rsp_data_q[r] <= '0;
            end
            for (int p = 0; p < WPORT_NUM; p++) begin
                skid_addr_q[p] <= '0;
                skid_mask_q[p] <= '0;
                skid_data_q[p] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            pend_q     <= pend_d;
            rsp_vld_q  <= rsp_vld_d;
            skid_vld_q <= skid_vld_d;
            wr_rdy_q   <= wr_rdy_d;
            raddr_q    <= raddr_d;
            rsp_data_q <= rsp_data_d;
            skid_addr_q <= skid_addr_d;
            skid_mask_q <= skid_mask_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WPORT_NUM; w++) begin
            if (wgnt[w]) begin
                mem_q[c_addr[w]] <= (mem_q[c_addr[w]] & ~c_mask[w]) | (c_data[w] & c_mask[w]);
            end
        end
    end

    assign bus.rd_req_rdy = rdy_q;
    assign bus.rd_rsp_vld = rsp_vld_q;
    assign bus.wr_rdy     = wr_rdy_q;

    for (genvar r = 0; r < RPORT_NUM; r++) begin : g_rsp
        assign bus.rd_rsp_data[r*VLEN +: VLEN] = rsp_data_q[r];
    end
endmodule

// File: tb/tb_vrf_banked_mp.sv
// tb_vrf_banked_mp: table-driven and randomized checks of vrf_banked_mp against a register-level model.
module tb_vrf_banked_mp;
    localparam int unsigned NB  = 4;
    localparam int unsigned BRP = 2;
    localparam int unsigned RP  = 3;
    localparam int unsigned WP  = 2;
    localparam int unsigned NV  = 32;
    localparam int unsigned VL  = 128;
    localparam int unsigned AW  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vrf_banked_mp_if #(.RPORT_NUM(RP), .WPORT_NUM(WP), .NUM_VREGS(NV), .VLEN(VL)) bus ();

    vrf_banked_mp #(
        .NUM_BANKS(NB), .BANK_RPORTS(BRP), .RPORT_NUM(RP),
        .WPORT_NUM(WP), .NUM_VREGS(NV), .VLEN(VL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [VL-1:0] mdl [NV];
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [RP-1:0] en;
        logic [AW-1:0] a0, a1, a2;
        int            k0, k1, k2;
        int            occ;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [VL-1:0] act, input logic [VL-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [VL-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Response cycle per port = 1 + (enabled lower ports on the same bank) / BRP.
    function automatic void model_sched(input logic [RP-1:0] en, input logic [RP*AW-1:0] ad,
                                        output logic [2*RP-1:0] k, output int occ);
        occ = 0;
        k   = '0;
        for (int p = 0; p < int'(RP); p++) begin
            if (en[p]) begin
                int rank;
                int kk;
                rank = 0;
                for (int q = 0; q < p; q++)
                    if (en[q] && (int'(ad[q*AW +: AW]) % NB == int'(ad[p*AW +: AW]) % NB)) rank++;
                kk = rank / BRP + 1;
                k[2*p +: 2] = 2'(kk);
                if (kk > occ) occ = kk;
            end
        end
    endfunction

    task automatic wr_cycle(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [VL-1:0] m0, input logic [VL-1:0] m1,
                            input logic [VL-1:0] d0, input logic [VL-1:0] d1);
        logic conflict;
        chk("wr_rdy_pre", VL'(bus.wr_rdy), VL'(2'b11));
        bus.wr_vld  = v;
        bus.wr_addr = {a1, a0};
        bus.wr_mask = {m1, m0};
        bus.wr_data = {d1, d0};
        tick();
        bus.wr_vld = '0;
        conflict = (v == 2'b11) && (int'(a0) % NB == int'(a1) % NB);
        if (v[0]) mdl[a0] = (mdl[a0] & ~m0) | (d0 & m0);
        if (v[1]) mdl[a1] = (mdl[a1] & ~m1) | (d1 & m1);
        chk("wr_rdy_accept", VL'(bus.wr_rdy), conflict ? VL'(2'b01) : VL'(2'b11));
        if (conflict) begin
            tick();
            chk("wr_rdy_drain", VL'(bus.wr_rdy), VL'(2'b11));
        end
    endtask

    task automatic rd_group(input string nm, input logic [RP-1:0] en, input logic [RP*AW-1:0] ad,
                            input logic [2*RP-1:0] k, input int occ);
        logic [VL-1:0] expd [RP];
        logic [RP-1:0] ev;
        int guard;
        guard = 0;
        while (!bus.rd_req_rdy && guard < 10) begin
            tick();
            guard++;
        end
        chk({nm, "_rdy_pre"}, VL'(bus.rd_req_rdy), VL'(1));
        for (int p = 0; p < int'(RP); p++) expd[p] = mdl[ad[p*AW +: AW]];
        bus.rd_req_vld  = 1'b1;
        bus.rd_req_en   = en;
        bus.rd_req_addr = ad;
        tick();
        bus.rd_req_vld = 1'b0;
        bus.rd_req_en  = '0;
        for (int j = 0; j <= occ + 1; j++) begin
            ev = '0;
            for (int p = 0; p < int'(RP); p++)
                if (en[p] && int'(k[2*p +: 2]) == j) ev[p] = 1'b1;
            chk({nm, "_vld"}, VL'(bus.rd_rsp_vld), VL'(ev));
            chk({nm, "_rdy"}, VL'(bus.rd_req_rdy), VL'(j >= occ));
            for (int p = 0; p < int'(RP); p++)
                if (ev[p] && bus.rd_rsp_vld[p]) chk({nm, "_data"}, bus.rd_rsp_data[p*VL +: VL], expd[p]);
            if (j <= occ) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [9];
        logic [VL-1:0] old2;
        logic [VL-1:0] exp6;
        logic [2*RP-1:0] kk;
        int            occ;

        tbl[0] = '{en: 3'b111, a0: 5'd0,  a1: 5'd1,  a2: 5'd2,  k0: 1, k1: 1, k2: 1, occ: 1};
        tbl[1] = '{en: 3'b111, a0: 5'd0,  a1: 5'd4,  a2: 5'd8,  k0: 1, k1: 1, k2: 2, occ: 2};
        tbl[2] = '{en: 3'b111, a0: 5'd3,  a1: 5'd3,  a2: 5'd3,  k0: 1, k1: 1, k2: 2, occ: 2};
        tbl[3] = '{en: 3'b110, a0: 5'd1,  a1: 5'd5,  a2: 5'd9,  k0: 0, k1: 1, k2: 1, occ: 1};
        tbl[4] = '{en: 3'b101, a0: 5'd4,  a1: 5'd4,  a2: 5'd8,  k0: 1, k1: 0, k2: 1, occ: 1};
        tbl[5] = '{en: 3'b000, a0: 5'd6,  a1: 5'd7,  a2: 5'd8,  k0: 0, k1: 0, k2: 0, occ: 0};
        tbl[6] = '{en: 3'b011, a0: 5'd27, a1: 5'd31, a2: 5'd0,  k0: 1, k1: 1, k2: 0, occ: 1};
        tbl[7] = '{en: 3'b111, a0: 5'd16, a1: 5'd13, a2: 5'd12, k0: 1, k1: 1, k2: 1, occ: 1};
        tbl[8] = '{en: 3'b111, a0: 5'd28, a1: 5'd24, a2: 5'd20, k0: 1, k1: 1, k2: 2, occ: 2};

        rst             = 1'b1;
        bus.rd_req_vld  = 1'b0;
        bus.rd_req_en   = '0;
        bus.rd_req_addr = '0;
        bus.wr_vld      = '0;
        bus.wr_addr     = '0;
        bus.wr_mask     = '0;
        bus.wr_data     = '0;
        tick();
        tick();
        chk("rst_rdy", VL'(bus.rd_req_rdy), VL'(1));
        chk("rst_rsp_vld", VL'(bus.rd_rsp_vld), VL'(0));
        chk("rst_rsp_data", bus.rd_rsp_data[VL-1:0], VL'(0));
        chk("rst_wr_rdy", VL'(bus.wr_rdy), VL'(2'b11));
        rst = 1'b0;
        tick();

        // Write then read back a single register
        wr_cycle(2'b01, 5'd5, 5'd0, '1, '0, {16{8'hA5}}, '0);
        rd_group("t1", 3'b001, {5'd0, 5'd0, 5'd5}, {2'd0, 2'd0, 2'd1}, 1);

        for (int i = 0; i < int'(NV); i += 2)
            wr_cycle(2'b11, AW'(i), AW'(i + 1), '1, '1, rnd_vec(), rnd_vec());

        foreach (tbl[i])
            rd_group($sformatf("tbl%0d", i), tbl[i].en, {tbl[i].a2, tbl[i].a1, tbl[i].a0},
                     {2'(tbl[i].k2), 2'(tbl[i].k1), 2'(tbl[i].k0)}, tbl[i].occ);

        // Two writes colliding on bank3
        wr_cycle(2'b11, 5'd3, 5'd7, '1, '1, {16{8'h11}}, {16{8'h22}});
        rd_group("t4", 3'b011, {5'd0, 5'd7, 5'd3}, {2'd0, 2'd1, 2'd1}, 1);

        // Partial mask
        wr_cycle(2'b01, 5'd9, 5'd0, '1, '0, '0, '0);
        wr_cycle(2'b01, 5'd9, 5'd0, {8{16'h00FF}}, '0, '1, '0);
        rd_group("t5", 3'b001, {5'd0, 5'd0, 5'd9}, {2'd0, 2'd0, 2'd1}, 1);

        // Read and write of v2 granted in the same cycle
        old2 = mdl[2];
`ifdef VRF_WR_BYPASS_EN
        exp6 = {16{8'h33}};
`else
        exp6 = old2;
`endif
        bus.rd_req_vld  = 1'b1;
        bus.rd_req_en   = 3'b001;
        bus.rd_req_addr = {5'd0, 5'd0, 5'd2};
        tick();
        bus.rd_req_vld = 1'b0;
        bus.rd_req_en  = '0;
        bus.wr_vld     = 2'b01;
        bus.wr_addr    = {5'd0, 5'd2};
        bus.wr_mask    = {{VL{1'b0}}, {VL{1'b1}}};
        bus.wr_data    = {{VL{1'b0}}, {16{8'h33}}};
        tick();
        bus.wr_vld = '0;
        chk("t6_vld", VL'(bus.rd_rsp_vld), VL'(3'b001));
        chk("t6_data", bus.rd_rsp_data[VL-1:0], exp6);
        mdl[2] = {16{8'h33}};
        tick();
        chk("t6_rdy_after", VL'(bus.rd_req_rdy), VL'(1));
        rd_group("t6_rb", 3'b001, {5'd0, 5'd0, 5'd2}, {2'd0, 2'd0, 2'd1}, 1);

        // Reset during SERVE discards the group
        bus.rd_req_vld  = 1'b1;
        bus.rd_req_en   = 3'b111;
        bus.rd_req_addr = {5'd8, 5'd4, 5'd0};
        tick();
        bus.rd_req_vld = 1'b0;
        bus.rd_req_en  = '0;
        chk("rstm_rdy_low", VL'(bus.rd_req_rdy), VL'(0));
        rst = 1'b1;
        #1;
        chk("rstm_vld", VL'(bus.rd_rsp_vld), VL'(0));
        chk("rstm_rdy", VL'(bus.rd_req_rdy), VL'(1));
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rstm_no_rsp", VL'(bus.rd_rsp_vld), VL'(0));
        end

        // Reset while a skid is held discards the skidded write
        bus.wr_vld  = 2'b11;
        bus.wr_addr = {5'd7, 5'd3};
        bus.wr_mask = '1;
        bus.wr_data = {{16{8'h55}}, {16{8'h44}}};
        tick();
        bus.wr_vld = '0;
        mdl[3] = {16{8'h44}};
        chk("rsts_wr_rdy", VL'(bus.wr_rdy), VL'(2'b01));
        rst = 1'b1;
        #1;
        chk("rsts_wr_rdy_rst", VL'(bus.wr_rdy), VL'(2'b11));
        tick();
        rst = 1'b0;
        tick();
        rd_group("rsts", 3'b011, {5'd0, 5'd7, 5'd3}, {2'd0, 2'd1, 2'd1}, 1);

        for (int it = 0; it < 40; it++) begin
            logic [RP-1:0]    en;
            logic [RP*AW-1:0] ad;
            wr_cycle(2'($urandom_range(1, 3)), AW'($urandom), AW'($urandom),
                     rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
            en = RP'($urandom);
            ad = (RP*AW)'($urandom);
            model_sched(en, ad, kk, occ);
            rd_group("rnd", en, ad, kk, occ);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
